// File: rtl/ram_d_arbiter_pkg.sv
// ram_d_arbiter_pkg
//   Shared types and constants for the ram_d arbiter and its round-robin
//   helper. The state encoding and the client indices are used both by the
//   arbiter top and by rr_arb2.
package ram_d_arbiter_pkg;

  // Top-level mode: IDLE arbitrates port A, CLEAR gives port A to the sweep.
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } arb_state_e;

  // Client indices. They also serve as bit positions in req/gnt vectors.
  localparam logic CLIENT0 = 1'b0;
  localparam logic CLIENT1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
//   Two-way round-robin arbiter with a registered "last granted" pointer.
//   A lone request is granted in the same cycle; on a tie the client that
//   was not granted most recently wins. The pointer resets to client 1, so
//   client 0 wins the first tie.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   en        : arbitration enable; with en low no grant is issued
//   req[1:0]  : request per client (bit index = client index)
//   gnt[1:0]  : combinational one-hot (or zero) grant
import ram_d_arbiter_pkg::*;

module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req[CLIENT0] && req[CLIENT1]) begin
        if (last == CLIENT1) gnt[CLIENT0] = 1'b1;
        else                 gnt[CLIENT1] = 1'b1;
      end else begin
        gnt = req;
      end
    end
  end

  // Pointer only moves on an actual grant so idle cycles keep fairness.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  last <= CLIENT1;
    else if (gnt[CLIENT0])    last <= CLIENT0;
    else if (gnt[CLIENT1])    last <= CLIENT1;
  end

endmodule

// File: rtl/ram_d_arbiter.sv
// ram_d_arbiter
//   Shares one ram_d neighbour-info buffer between two clients and owns its
//   initialisation. Port A is round-robin shared between client 0 and
//   client 1; port B is a read-only lookup for client 1. A clear engine
//   sweeps every word to clr_val on start_clr, since ram_d has no reset.
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   start_clr, clr_busy, clr_done: clear sweep control/status
//   req0/we0/addr0/wdata0, gnt0  : client 0 port-A request / grant
//   rvalid0, rdata0              : client 0 read return
//   req1/we1/addr1/wdata1, gnt1  : client 1 port-A request / grant
//   rvalid1, rdata1              : client 1 read return
//   addrb1, rdatab1              : client 1 port-B lookup
//   ram_en, ram_we, ram_addra, ram_addrb, ram_dia, ram_doa, ram_dob:
//                                  attached ram_d (1-cycle read latency)
import ram_d_arbiter_pkg::*;

module ram_d_arbiter #(
  parameter int                   addr_bits = 8,
  parameter int                   data_bits = 16,
  parameter logic [data_bits-1:0] clr_val   = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_clr,
  output logic                 clr_busy,
  output logic                 clr_done,
  input  logic                 req0,
  input  logic                 we0,
  input  logic [addr_bits-1:0] addr0,
  input  logic [data_bits-1:0] wdata0,
  output logic                 gnt0,
  output logic                 rvalid0,
  output logic [data_bits-1:0] rdata0,
  input  logic                 req1,
  input  logic                 we1,
  input  logic [addr_bits-1:0] addr1,
  input  logic [data_bits-1:0] wdata1,
  output logic                 gnt1,
  output logic                 rvalid1,
  output logic [data_bits-1:0] rdata1,
  input  logic [addr_bits-1:0] addrb1,
  output logic [data_bits-1:0] rdatab1,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [addr_bits-1:0] ram_addra,
  output logic [addr_bits-1:0] ram_addrb,
  output logic [data_bits-1:0] ram_dia,
  input  logic [data_bits-1:0] ram_doa,
  input  logic [data_bits-1:0] ram_dob
);

  arb_state_e           state;
  logic [addr_bits-1:0] cnt;
  logic [1:0]           gnt;
  logic                 arb_en;

  // Clear sweep FSM. cnt is the address being written this cycle; the sweep
  // leaves on the edge that writes the all-ones address, so clr_busy is
  // high for exactly 2^addr_bits cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_clr) begin
            state    <= CLEAR;
            cnt      <= '0;
            clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          // start_clr is deliberately ignored here.
          if (cnt == '1) begin
            state    <= IDLE;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A request coinciding with start_clr loses to the clear; nothing is
  // granted while reset is asserted.
  assign arb_en = (state == IDLE) && !start_clr && !rst;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .en  (arb_en),
    .req ({req1, req0}),
    .gnt (gnt)
  );

  assign gnt0 = gnt[CLIENT0];
  assign gnt1 = gnt[CLIENT1];

  // Port A mux. With no grant the address defaults to client 1's.
  always_comb begin
    ram_addra = addr1;
    ram_dia   = wdata1;
    ram_we    = 1'b0;
    if (state == CLEAR) begin
      ram_addra = cnt;
      ram_dia   = clr_val;
      ram_we    = 1'b1;
    end else if (gnt[CLIENT0]) begin
      ram_addra = addr0;
      ram_dia   = wdata0;
      ram_we    = we0;
    end else if (gnt[CLIENT1]) begin
      ram_we    = we1;
    end
  end

  // Read-return flags line up with the RAM's one-cycle output latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      ram_en  <= 1'b0;
    end else begin
      rvalid0 <= gnt[CLIENT0] && !we0;
      rvalid1 <= gnt[CLIENT1] && !we1;
      ram_en  <= 1'b1;
    end
  end

  assign rdata0    = ram_doa;
  assign rdata1    = ram_doa;
  assign ram_addrb = addrb1;
  assign rdatab1   = ram_dob;

endmodule

// File: tb/tb_ram_d_arbiter.sv
// tb_ram_d_arbiter
//   Bench for ram_d_arbiter with addr_bits=4. A simple read-first dual-port
//   RAM is attached; expected values come from a reference model holding
//   the RAM contents, the sweep progress and the last tie winner.
module tb_ram_d_arbiter;

  localparam int AB = 4;
  localparam int DB = 16;
  localparam int NW = 1 << AB;
  localparam logic [DB-1:0] CLR = 16'h5A5A;

  logic          clk, rst, start_clr, clr_busy, clr_done;
  logic          req0, we0, gnt0, rvalid0, req1, we1, gnt1, rvalid1;
  logic [AB-1:0] addr0, addr1, addrb1, ram_addra, ram_addrb;
  logic [DB-1:0] wdata0, wdata1, rdata0, rdata1, rdatab1, ram_dia, ram_doa, ram_dob;
  logic          ram_en, ram_we;

  ram_d_arbiter #(.addr_bits(AB), .data_bits(DB), .clr_val(CLR)) dut (
    .clk(clk), .rst(rst), .start_clr(start_clr), .clr_busy(clr_busy), .clr_done(clr_done),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0),
    .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1),
    .rvalid1(rvalid1), .rdata1(rdata1),
    .addrb1(addrb1), .rdatab1(rdatab1),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addra(ram_addra), .ram_addrb(ram_addrb),
    .ram_dia(ram_dia), .ram_doa(ram_doa), .ram_dob(ram_dob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Attached ram_d: synchronous, read-before-write on both ports.
  logic [DB-1:0] ram [NW];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram[ram_addra] <= ram_dia;
      ram_doa <= ram[ram_addra];
      ram_dob <= ram[ram_addrb];
    end
  end

  // Reference model state
  logic [DB-1:0] mdl_mem [NW];
  bit            known [NW];
  int            clr_left, sweep_addr, prev_w;
  int            n_chk, n_pass, busy_obs, done_obs;
  logic          g0_seen, g1_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs are already driven; check the combinational
  // grant, take the edge, update the model, check the registered results.
  task automatic step();
    bit eg0, eg1, busy, exp_done, ev0, ev1, ek0, ek1, bk;
    logic [DB-1:0] er0, er1, bv;
    #1;
    busy = (clr_left > 0);
    eg0 = 0; eg1 = 0;
    if (!busy && !start_clr) begin
      if (req0 && req1) begin
        if (prev_w == 1) eg0 = 1; else eg1 = 1;
      end else begin
        eg0 = req0; eg1 = req1;
      end
    end
    chk("gnt0", gnt0, eg0);
    chk("gnt1", gnt1, eg1);
    chk("ram_we", ram_we, busy ? 1'b1 : ((eg0 && we0) || (eg1 && we1)));
    if (busy) begin
      chk("sweep_addr", ram_addra, sweep_addr);
      chk("sweep_data", ram_dia, CLR);
    end
    g0_seen = gnt0; g1_seen = gnt1;
    bk = known[addrb1]; bv = mdl_mem[addrb1];
    @(posedge clk);
    exp_done = 0; ev0 = 0; ev1 = 0; ek0 = 0; ek1 = 0; er0 = '0; er1 = '0;
    if (busy) begin
      mdl_mem[sweep_addr] = CLR; known[sweep_addr] = 1;
      sweep_addr++; clr_left--;
      if (clr_left == 0) exp_done = 1;
    end else if (start_clr) begin
      clr_left = NW; sweep_addr = 0;
    end
    if (eg0) begin
      prev_w = 0;
      if (we0) begin mdl_mem[addr0] = wdata0; known[addr0] = 1; end
      else begin ev0 = 1; er0 = mdl_mem[addr0]; ek0 = known[addr0]; end
    end
    if (eg1) begin
      prev_w = 1;
      if (we1) begin mdl_mem[addr1] = wdata1; known[addr1] = 1; end
      else begin ev1 = 1; er1 = mdl_mem[addr1]; ek1 = known[addr1]; end
    end
    #1;
    chk("clr_busy", clr_busy, clr_left > 0);
    chk("clr_done", clr_done, exp_done);
    chk("rvalid0", rvalid0, ev0);
    chk("rvalid1", rvalid1, ev1);
    if (ev0 && ek0) chk("rdata0", rdata0, er0);
    if (ev1 && ek1) chk("rdata1", rdata1, er1);
    if (bk) chk("rdatab1", rdatab1, bv);
    if (clr_busy) busy_obs++;
    if (clr_done) done_obs++;
  endtask

  initial begin
    int first_g0;
    n_chk = 0; n_pass = 0; busy_obs = 0; done_obs = 0;
    clr_left = 0; sweep_addr = 0; prev_w = 1;
    for (int i = 0; i < NW; i++) begin known[i] = 0; mdl_mem[i] = '0; end
    rst = 1; start_clr = 0;
    req0 = 1; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0; addrb1 = '0;

    // Reset state
    #2;
    chk("rst_clr_busy", clr_busy, 1'b0);
    chk("rst_clr_done", clr_done, 1'b0);
    chk("rst_rvalid0", rvalid0, 1'b0);
    chk("rst_rvalid1", rvalid1, 1'b0);
    chk("rst_ram_we", ram_we, 1'b0);
    chk("rst_gnt0", gnt0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ram_en", ram_en, 1'b0);
    req0 = 0; rst = 0;
    @(posedge clk); #1;
    chk("ram_en_up", ram_en, 1'b1);

    // Clear sweep with req0 pending and a second start_clr mid-sweep
    start_clr = 1; req0 = 1; we0 = 0; addr0 = 4'd3;
    step();
    chk("start_beats_req", g0_seen, 1'b0);
    start_clr = 0;
    first_g0 = -1;
    for (int i = 0; i < 20; i++) begin
      start_clr = (i == 6);
      step();
      if (g0_seen && first_g0 < 0) first_g0 = i;
      if (g0_seen) req0 = 0;
    end
    start_clr = 0;
    chk("sweep_len", busy_obs, NW);
    chk("done_pulses", done_obs, 1);
    chk("gnt0_after_clear", first_g0, 16);

    // Read back every address, alternating clients
    for (int a = 0; a < NW; a++) begin
      if (a % 2 == 0) begin req0 = 1; we0 = 0; addr0 = a[AB-1:0]; end
      else begin req1 = 1; we1 = 0; addr1 = a[AB-1:0]; end
      step();
      chk("clr_readback", (a % 2 == 0) ? rdata0 : rdata1, CLR);
      req0 = 0; req1 = 0;
    end

    // Simultaneous reads: grants alternate starting with client 0
    req0 = 1; req1 = 1; we0 = 0; we1 = 0;
    for (int i = 0; i < 4; i++) begin
      addr0 = AB'($urandom); addr1 = AB'($urandom);
      step();
      chk("tie_gnt0", g0_seen, (i % 2) == 0);
      chk("tie_rvalid1", rvalid1, (i % 2) == 1);
    end
    req0 = 0; req1 = 0;

    // Write then read next cycle through the other client
    req0 = 1; we0 = 1; addr0 = 4'd5; wdata0 = 16'h1234;
    step();
    req0 = 0; req1 = 1; we1 = 0; addr1 = 4'd5;
    step();
    chk("wr_rd_rvalid1", rvalid1, 1'b1);
    chk("wr_rd_rdata1", rdata1, 16'h1234);
    req1 = 0;

    // Port-B read colliding with a port-A write
    req0 = 1; we0 = 1; addr0 = 4'd7; wdata0 = 16'hBEEF; addrb1 = 4'd7;
    step();
    chk("collide_old", rdatab1, CLR);
    req0 = 0;
    step();
    chk("collide_new", rdatab1, 16'hBEEF);

    // Randomised traffic with the valid/grant handshake
    g0_seen = 1; g1_seen = 1;
    for (int n = 0; n < 400; n++) begin
      if (!req0 || g0_seen) begin
        req0 = $urandom_range(0, 1); we0 = $urandom_range(0, 1);
        addr0 = AB'($urandom); wdata0 = DB'($urandom);
      end
      if (!req1 || g1_seen) begin
        req1 = $urandom_range(0, 1); we1 = $urandom_range(0, 1);
        addr1 = AB'($urandom); wdata1 = DB'($urandom);
      end
      addrb1 = AB'($urandom);
      start_clr = ($urandom_range(0, 79) == 0);
      step();
    end
    start_clr = 0; req0 = 0; req1 = 0;
    for (int n = 0; n < NW + 2; n++) step();

    // Reset in the middle of a sweep
    start_clr = 1; req0 = 1; we0 = 0; addr0 = 4'd2;
    step();
    start_clr = 0;
    repeat (5) step();
    rst = 1;
    #1;
    chk("mid_rst_busy", clr_busy, 1'b0);
    chk("mid_rst_we", ram_we, 1'b0);
    chk("mid_rst_rvalid0", rvalid0, 1'b0);
    chk("mid_rst_gnt0", gnt0, 1'b0);
    chk("mid_rst_done", clr_done, 1'b0);
    clr_left = 0; prev_w = 1;
    @(posedge clk); #1;
    req0 = 0; rst = 0;
    @(posedge clk); #1;
    chk("mid_rst_ram_en", ram_en, 1'b1);
    busy_obs = 0; done_obs = 0;
    step();
    start_clr = 1;
    step();
    start_clr = 0;
    repeat (NW + 1) step();
    chk("resweep_len", busy_obs, NW);
    chk("resweep_done", done_obs, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ram_d_arbiter.md
# ram_d_arbiter

Shares a single `ram_d` neighbour-info buffer (intra pred modes, ref_idx, mvp) between two requesters and owns its initialisation. Port A is time-shared between client 0 and client 1 under round-robin arbitration; port B is a dedicated read-only lookup for client 1. A built-in clear engine sweeps every RAM word to a constant at picture or slice start, because `ram_d` has no reset. The block sits between the CTU-level producers/consumers and one `ram_d` instance.

## Interface
- `addr_bits`, 8: RAM address width; must match the attached `ram_d`.
- `data_bits`, 16: RAM word width.
- `clr_val`, 0: word written to every address by the clear sweep.

Ports:
- `clk` in 1: the single clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start_clr` in 1: one-cycle pulse that starts the clear sweep.
- `clr_busy` out 1: high while the sweep is running.
- `clr_done` out 1: one-cycle pulse when the sweep completes.
- `req0`, `we0` in 1: client 0 request and write-enable.
- `addr0` in addr_bits, `wdata0` in data_bits: client 0 address and write data.
- `gnt0` out 1: client 0 grant (combinational).
- `rvalid0` out 1, `rdata0` out data_bits: client 0 read return.
- `req1`, `we1`, `addr1`, `wdata1`, `gnt1`, `rvalid1`, `rdata1`: client 1, same meanings as client 0.
- `addrb1` in addr_bits: client 1 port-B read address.
- `rdatab1` out data_bits: client 1 port-B read data.
- `ram_en`, `ram_we` out 1: RAM enable and write-enable.
- `ram_addra`, `ram_addrb` out addr_bits: RAM port addresses.
- `ram_dia` out data_bits: RAM write data.
- `ram_doa`, `ram_dob` in data_bits: RAM read data.

## Operation
- FSM states:
  - IDLE: arbitration is active.
  - CLEAR: the sweep owns port A.
- Transitions:
  - IDLE→CLEAR on `start_clr`.
  - CLEAR→IDLE after the write to address 2^addr_bits−1.
  - `start_clr` while in CLEAR is ignored.
- CLEAR:
  - `ram_we`=1, `ram_addra`=sweep counter, `ram_dia`=`clr_val`.
  - The counter starts at 0 and increments by 1 per cycle, with no wrap beyond the last address.
  - `gnt0` and `gnt1` are 0; client requests stay pending.
- IDLE arbitration:
  - One request: that client is granted in the same cycle.
  - Both requests: grant goes to the client not granted most recently; the `last` pointer resets to 1, so client 0 wins the first tie.
  - `last` updates only on a grant.
- Granted cycle:
  - `ram_addra`, `ram_we` and `ram_dia` come from the winner.
  - With no grant: `ram_we`=0 and `ram_addra` holds client 1's address.
- Handshake:
  - A client holds req/we/addr/wdata stable until it sees gnt high at a clock edge.
  - A transfer is complete on any edge where req&&gnt.
- Read return:
  - A granted read (`we`=0) sets that client's `rvalid` in the next cycle.
  - `rdataN` = `ram_doa` (combinational pass-through) and is valid only while `rvalidN`=1.
  - Writes produce no `rvalid`.
- Port B: `ram_addrb` = `addrb1` every cycle; `rdatab1` = `ram_dob`, one cycle later, unconditionally.
- `ram_en` is a register: reset 0, 1 from the first clock after reset deassertion.
- Collisions:
  - A port-B read and a port-A write to the same address in the same cycle return the pre-write word.
  - A port-A write followed by a read of the same address in the next cycle returns the new word.

## Timing
- Reset values: `clr_busy`=0, `clr_done`=0, `rvalid0/1`=0, `ram_en`=0, FSM=IDLE, counter=0, `last`=1.
- While in reset, `ram_we`=0 and `gnt0/1`=0.
- Read latency is 1 cycle from the grant edge to `rvalid`; back-to-back grants give one access per cycle.
- Clear sweep:
  - `start_clr` sampled at edge T makes `clr_busy` high from T+1 for exactly 2^addr_bits cycles.
  - `clr_done` pulses in the first cycle `clr_busy` is low again.
  - A request arriving at the same edge as `start_clr` loses: the clear takes precedence.
- Reset mid-sweep aborts the sweep and leaves the RAM partially cleared; software must restart the clear.

## Structure
- Shared package/defines: `ram_d_arb` state encodings (IDLE=0, CLEAR=1) and the client index constants.
- One natural sub-module: `rr_arb2` (2-way round-robin with a `last` register), reusable by other RAM arbiters in the decoder.

## Test plan
- **Clear sweep:** `start_clr` with addr_bits=4, then client reads of all 16 addresses.
  - `clr_busy` is high for exactly 16 cycles and `clr_done` pulses once.
  - Every read returns `clr_val`.
- **Simultaneous requests:** `req0`=`req1`=1 held for 4 cycles, both reads.
  - Grants alternate 0,1,0,1.
  - Each `rvalid` follows its grant by one cycle.
- **Write then read:** client 0 writes 0x1234 at address 5, then client 1 reads address 5 in the next cycle.
  - `rvalid1`=1 with `rdata1`=0x1234.
- **Port-B collision:** port-B read of address 7 in the same cycle as a port-A write of 0xBEEF to address 7.
  - `rdatab1` returns the old value.
  - A port-B read of address 7 one cycle later returns 0xBEEF.
- **Requests during clear:** `req0` held high while in CLEAR, plus a second `start_clr` mid-sweep.
  - `gnt0`=0 until the cycle after the last clear write, then `gnt0`=1.
  - The sweep length is unchanged by the second `start_clr`.
- **Reset mid-sweep:** `rst` asserted mid-sweep.
  - `clr_busy`, `ram_we` and `rvalid` go to 0 immediately, with no `clr_done`.
  - A new `start_clr` runs a full sweep.
